// File: rtl/divider_8bits.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results
// held in registers and gated onto the shared result bus by en.
`timescale 1ns/1ps
module divider_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] quo_r, div_r, rem_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] q_r, r_r;
  logic             div_zero_r, busy_r, done_r;

  logic [WIDTH:0]   t_s, diff_s;
  logic             ge_s, last_s, accept_s, b_zero_s;
  logic [WIDTH-1:0] quo_nxt_s, rem_nxt_s;
  logic             busy_nxt_s, done_nxt_s;

  // One restoring step. The partial remainder stays below the divisor, so t < 2*div
  // and the borrow out of the (WIDTH+1)-bit subtraction is exactly "t < div".
  always_comb begin
    t_s       = {rem_r, quo_r[WIDTH-1]};
    diff_s    = t_s - {1'b0, div_r};
    ge_s      = ~diff_s[WIDTH];
    quo_nxt_s = {quo_r[WIDTH-2:0], ge_s};
    rem_nxt_s = ge_s ? diff_s[WIDTH-1:0] : t_s[WIDTH-1:0];
    last_s    = (cnt_r == LAST_CNT);
    accept_s  = (state_r == IDLE) && start;
    b_zero_s  = (b == {WIDTH{1'b0}});
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a zero divisor skips the iterations entirely.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = b_zero_s ? FIN : CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode feeding the status registers; done trails FIN by one edge so it
  // lands in the IDLE cycle where a back-to-back start can be accepted.
  always_comb begin
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_r == FIN);
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_r <= {WIDTH{1'b0}};
      div_r <= {WIDTH{1'b0}};
      rem_r <= {WIDTH{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      quo_r <= a;
      div_r <= b;
      rem_r <= {WIDTH{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (state_r == CALC) begin
      quo_r <= quo_nxt_s;
      rem_r <= rem_nxt_s;
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Result registers change only when FIN is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r        <= {WIDTH{1'b0}};
      r_r        <= {WIDTH{1'b0}};
      div_zero_r <= 1'b0;
    end else if (accept_s && b_zero_s) begin
      q_r        <= {WIDTH{1'b1}};
      r_r        <= a;
      div_zero_r <= 1'b1;
    end else if ((state_r == CALC) && last_s) begin
      q_r        <= quo_nxt_s;
      r_r        <= rem_nxt_s;
      div_zero_r <= 1'b0;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign q        = en ? q_r : {WIDTH{1'bz}};
  assign r        = en ? r_r : {WIDTH{1'bz}};
  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;

endmodule

// File: tb/tb_divider_8bits.sv
// Randomized self-checking bench for divider_8bits against a plain-arithmetic
// quotient/remainder model, plus directed latency, abort and output-enable cases.
`timescale 1ns/1ps
module tb_divider_8bits;

  logic       clk, rst_n, start, en;
  logic [7:0] a, b, q, r;
  logic       busy, done, div_zero;
  int         checks, errors;
  logic [7:0] zz;

  divider_8bits #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .en(en),
    .q(q), .r(r), .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at the current negedge; inj>0 re-pulses start (a=1,b=1) that many
  // cycles after acceptance. Returns at the negedge where done is first seen.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input int inj);
    int n, bc;
    logic [7:0] eq, er;
    a = ta; b = tb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = tb + 8'd3;
    n = 0; bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
      if (n == inj) begin start = 1'b1; a = 8'd1; b = 8'd1; end
      else start = 1'b0;
    end
    eq = (tb == 8'd0) ? 8'hFF : ta / tb;
    er = (tb == 8'd0) ? ta : ta % tb;
    chk("latency", 16'(n), (tb == 8'd0) ? 16'd1 : 16'd9);
    chk("busy_cycles", 16'(bc), (tb == 8'd0) ? 16'd1 : 16'd9);
    chk("quotient", {8'd0, q}, {8'd0, en ? eq : zz});
    chk("remainder", {8'd0, r}, {8'd0, en ? er : zz});
    chk("div_zero", {15'd0, div_zero}, {15'd0, tb == 8'd0});
    if (en && tb != 8'd0) chk("identity", 16'(q) * 16'(tb) + 16'(r), 16'(ta));
  endtask

  initial begin
    checks = 0; errors = 0; zz = 8'hzz;
    rst_n = 1'b0; start = 1'b0; en = 1'b1; a = 8'd0; b = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_q", {8'd0, q}, 16'd0);
    chk("rst_r", {8'd0, r}, 16'd0);
    chk("rst_status", {13'd0, busy, done, div_zero}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd200, 8'd7, -1);
    @(negedge clk);
    chk("done_pulse", {15'd0, done}, 16'd0);
    chk("hold_q", {8'd0, q}, 16'd28);

    run_op(8'd255, 8'd1, -1);
    run_op(8'd3, 8'd10, -1);   // back-to-back in the done cycle
    run_op(8'd5, 8'd0, -1);
    run_op(8'd9, 8'd3, -1);
    run_op(8'd100, 8'd9, 3);   // second start while busy is ignored
    repeat (2) @(negedge clk);

    // abort mid-calculation
    a = 8'd50; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_q", {8'd0, q}, 16'd0);
    chk("abort_r", {8'd0, r}, 16'd0);
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", {15'd0, done}, 16'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd50, 8'd3, -1);

    // output enable gates only the result bus
    en = 1'b0;
    run_op(8'd77, 8'd0, -1);
    run_op(8'd77, 8'd5, -1);
    en = 1'b1;
    #1;
    chk("en_restore_q", {8'd0, q}, 16'd15);
    chk("en_restore_r", {8'd0, r}, 16'd2);
    @(negedge clk);

    // corners then random
    run_op(8'd0, 8'd1, -1);
    run_op(8'd0, 8'd255, -1);
    run_op(8'd254, 8'd255, -1);
    run_op(8'd255, 8'd255, -1);
    run_op(8'd128, 8'd2, -1);
    run_op(8'd0, 8'd0, -1);
    for (int i = 0; i < 1200; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      en = ($urandom_range(0, 7) != 0);
      run_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
